// File: rtl/vector_mac_lanes.sv
// Dot product of two INT8 vectors using LANES parallel multipliers, an adder tree and
// an ACC_W+8 bit accumulator, with tail-lane masking, valid/ready streams and sticky overflow.
module vector_mac_lanes #(
  parameter int LANES = 4,
  parameter int ACC_W = 32,
  parameter int LEN_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_signed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_a,
  input  logic [8*LANES-1:0] in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_sum,
  output logic               out_overflow,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshakes: a beat transfers on any edge where in_valid && in_ready, and a result
  // transfers where out_valid && out_ready; ready never depends on the matching valid.

  localparam int SW = 17 + $clog2(LANES);
  localparam int IW = ACC_W + 8;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("vector_mac_lanes: LANES must be 1, 2, 4 or 8");
  end
  if (ACC_W < 20 || ACC_W > 48) begin : g_bad_acc_w
    $error("vector_mac_lanes: ACC_W must be in 20..48");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;

  logic                    mode_q;
  logic [LEN_W:0]          beats_q;
  logic [LEN_W-1:0]        rem_q;
  logic                    s0_v, s1_v, s2_v;
  logic [8*LANES-1:0]      s0_a, s0_b;
  logic [LANES-1:0]        s0_mask;
  logic signed [16:0]      s1_p [LANES];
  logic signed [SW-1:0]    s2_sum;
  logic [IW-1:0]           acc_q;
  logic                    ovf_q;

  logic                    accept;
  logic                    last_beat;
  logic [LEN_W:0]          beats_init;
  logic [LEN_W-1:0]        rem_init;
  logic [LANES-1:0]        beat_mask;
  logic signed [8:0]       ea [LANES];
  logic signed [8:0]       eb [LANES];
  logic signed [16:0]      prod [LANES];
  logic signed [SW-1:0]    tree;
  logic [IW-1:0]           sum_ext;
  logic [IW-1:0]           acc_next;
  logic                    ovf_now;

  assign in_ready     = (state_q == RUN);
  assign out_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign dbg_state    = state_q;
  assign out_sum      = acc_q[ACC_W-1:0];
  assign out_overflow = ovf_q;

  assign accept     = in_valid && in_ready;
  assign last_beat  = (beats_q == (LEN_W+1)'(1));
  assign beats_init = ({1'b0, cfg_len} + (LEN_W+1)'(LANES - 1)) >> $clog2(LANES);
  assign rem_init   = cfg_len & LEN_W'(LANES - 1);

  // Only the final beat is masked; a zero remainder means the tail beat is full.
  always_comb begin
    beat_mask = '1;
    for (int k = 0; k < LANES; k++) begin
      beat_mask[k] = !last_beat || (rem_q == '0) || (LEN_W'(k) < rem_q);
    end
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      ea[k]   = {mode_q & s0_a[8*k+7], s0_a[8*k +: 8]};
      eb[k]   = {mode_q & s0_b[8*k+7], s0_b[8*k +: 8]};
      prod[k] = s0_mask[k] ? (17'(ea[k]) * 17'(eb[k])) : 17'sd0;
    end
  end

  always_comb begin
    tree = '0;
    for (int k = 0; k < LANES; k++) begin
      tree = tree + SW'(s1_p[k]);
    end
  end

  always_comb begin
    if (mode_q) sum_ext = IW'(s2_sum);
    else        sum_ext = IW'($unsigned(s2_sum));
    acc_next = acc_q + sum_ext;
    if (mode_q) ovf_now = !((&acc_next[IW-1:ACC_W-1]) || !(|acc_next[IW-1:ACC_W-1]));
    else        ovf_now = |acc_next[IW-1:ACC_W];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = (cfg_len == '0) ? DONE : RUN;
      RUN:   if (accept && last_beat) state_d = DRAIN;
      DRAIN: if (!s0_v && !s1_v && !s2_v) state_d = DONE;
      DONE:  if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      beats_q <= '0;
      rem_q   <= '0;
      s0_v    <= 1'b0;
      s1_v    <= 1'b0;
      s2_v    <= 1'b0;
      s0_a    <= '0;
      s0_b    <= '0;
      s0_mask <= '0;
      for (int k = 0; k < LANES; k++) s1_p[k] <= '0;
      s2_sum  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_v    <= accept;
      s1_v    <= s0_v;
      s2_v    <= s1_v;
      if (accept) begin
        s0_a    <= in_a;
        s0_b    <= in_b;
        s0_mask <= beat_mask;
      end
      if (s0_v) begin
        for (int k = 0; k < LANES; k++) s1_p[k] <= prod[k];
      end
      if (s1_v) s2_sum <= tree;
      if (state_q == IDLE && start) begin
        mode_q  <= cfg_signed;
        beats_q <= beats_init;
        rem_q   <= rem_init;
        acc_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (accept) beats_q <= beats_q - (LEN_W+1)'(1);
        if (s2_v) begin
          acc_q <= acc_next;
          ovf_q <= ovf_q | ovf_now;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mac_lanes.sv
// Randomised scoreboard bench for vector_mac_lanes: a driver issues vectors and pushes
// model results into exp_q, a monitor pops and compares on each result handshake.
module tb_vector_mac_lanes;

  localparam int LANES = 4;
  localparam int ACC_W = 20;
  localparam int LEN_W = 16;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_signed;
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_a;
  logic [8*LANES-1:0] in_b;
  logic               out_valid;
  logic               out_ready;
  logic [ACC_W-1:0]   out_sum;
  logic               out_overflow;
  logic               busy;
  logic [1:0]         dbg_state;

  vector_mac_lanes #(.LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .cfg_signed(cfg_signed),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_overflow(out_overflow), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [ACC_W:0] exp_q[$];
  logic [7:0] va [128];
  logic [7:0] vb [128];
  bit bubbles = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: plain integer dot product, overflow tested after each beat
  function automatic logic [ACC_W:0] model(input int len, input bit sgn);
    longint s = 0;
    bit ovf = 1'b0;
    longint lim = longint'(1) << (ACC_W - 1);
    int nbeats = (len + LANES - 1) / LANES;
    logic [63:0] s64;
    for (int b = 0; b < nbeats; b++) begin
      for (int l = 0; l < LANES; l++) begin
        int i = b * LANES + l;
        if (i < len) begin
          if (sgn) s += longint'($signed(va[i])) * longint'($signed(vb[i]));
          else     s += longint'(va[i]) * longint'(vb[i]);
        end
      end
      if (sgn) begin
        if (s < -lim || s > lim - 1) ovf = 1'b1;
      end else begin
        if (s >= 2 * lim) ovf = 1'b1;
      end
    end
    s64 = s;
    return {ovf, s64[ACC_W-1:0]};
  endfunction

  // driver
  task automatic run_vector(input int len, input bit sgn, input int hold, input bit start_in_done);
    logic [ACC_W:0] exp;
    int nbeats = (len + LANES - 1) / LANES;
    cfg_len = LEN_W'(len);
    cfg_signed = sgn;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_len = LEN_W'($urandom);
    cfg_signed = 1'($urandom);
    exp = model(len, sgn);
    exp_q.push_back(exp);
    if (len == 0) begin
      check("zero_len_valid", {63'd0, out_valid}, 64'd1);
    end else begin
      for (int b = 0; b < nbeats; b++) begin
        bit ok = 1'b0;
        int budget = 0;
        while (!ok) begin
          in_valid = bubbles ? ($urandom_range(0, 3) != 0) : 1'b1;
          for (int l = 0; l < LANES; l++) begin
            in_a[8*l +: 8] = in_valid ? va[b*LANES+l] : 8'($urandom);
            in_b[8*l +: 8] = in_valid ? vb[b*LANES+l] : 8'($urandom);
          end
          @(negedge clk);
          ok = in_valid && in_ready;
          @(posedge clk); #1;
          budget++;
          if (budget > 50) begin
            check("beat_accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
          end
        end
      end
      in_valid = 1'b0;
      check("in_ready_after_last", {63'd0, in_ready}, 64'd0);
      for (int c = 1; c <= 4; c++) begin
        @(posedge clk); #1;
        check("latency_out_valid", {63'd0, out_valid}, (c == 4) ? 64'd1 : 64'd0);
      end
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 1 && start_in_done) begin
        cfg_len = LEN_W'(3);
        start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("done_hold", {42'd0, out_valid, busy, exp}, {42'd0, 1'b1, 1'b1, exp});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_to_idle", {62'd0, busy, out_valid}, 64'd0);
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        check("result", {43'd0, out_overflow, out_sum}, {43'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    cfg_len = '0;
    cfg_signed = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {40'd0, in_ready, out_valid, busy, out_overflow, out_sum}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // unsigned 1*2 over 8 elements, continuous valid
    for (int i = 0; i < 128; i++) begin va[i] = 8'd1; vb[i] = 8'd2; end
    run_vector(8, 1'b0, 0, 1'b0);

    // signed -128*-128 and unsigned 255*255
    for (int i = 0; i < 128; i++) begin va[i] = 8'h80; vb[i] = 8'h80; end
    run_vector(4, 1'b1, 0, 1'b0);
    for (int i = 0; i < 128; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    run_vector(4, 1'b0, 0, 1'b0);

    // tail masking with garbage in lanes 1..3 of the last beat
    for (int i = 0; i < 4; i++) begin va[i] = 8'd1; vb[i] = 8'd1; end
    va[4] = 8'd3; vb[4] = 8'd3;
    for (int i = 5; i < 8; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    run_vector(5, 1'b0, 0, 1'b0);

    // unsigned overflow beyond 2^ACC_W
    for (int i = 0; i < 128; i++) begin va[i] = 8'hFF; vb[i] = 8'hFF; end
    run_vector(64, 1'b0, 0, 1'b0);

    // back-pressure in DONE with an ignored start
    for (int i = 0; i < 128; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
    run_vector(7, 1'b1, 6, 1'b1);

    // randomised vectors with bubbles
    bubbles = 1'b1;
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 128; i++) begin va[i] = 8'($urandom); vb[i] = 8'($urandom); end
      run_vector($urandom_range(0, 23), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end
    bubbles = 1'b0;

    // reset in the middle of a vector, then a zero-length vector
    cfg_len = LEN_W'(12);
    cfg_signed = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_a = '1;
    in_b = '1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mid_run_reset", {40'd0, in_ready, out_valid, busy, out_overflow, out_sum}, 64'd0);
    @(posedge clk); #1;
    check("idle_after_reset", {62'd0, busy, out_valid}, 64'd0);
    run_vector(0, 1'b0, 2, 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
